adc_serial_rx: RTL
==================

Name: adc_serial_rx

Overview:
Receives a serial ADC word in the `clk` domain. `sclk` is a divided clock generated in the same `clk` domain, and `cs_n` is an active-low frame strobe. The block detects `sclk` edges by registered comparison, shifts `sdata` in MSB-first, and presents a parallel word with a one-cycle valid pulse. It is the capture end of the ADC serial link that the team's clock divider drives, and it is used in both the ADC testbench and the FPGA front end.

Parameters:
DATA_WIDTH, 12, bits per conversion word.
SAMPLE_RISING, 1, 1 = sample `sdata` on `sclk` rising edge, 0 = falling edge.
TIMEOUT_CYCLES, 64, max `clk` cycles between sample edges inside a frame before error.
CNT_WIDTH, $clog2(DATA_WIDTH+1), bit counter width (derived).
TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived).

Ports:
clk  input  1  system clock; the single clock of the block.
rst  input  1  synchronous, active-high reset.
sclk  input  1  serial clock, synchronous to `clk` (divided from it).
cs_n  input  1  frame select, active low.
sdata  input  1  serial data, MSB first.
data_out  output  DATA_WIDTH  last complete word; holds until next completion.
data_valid  output  1  one-cycle pulse when `data_out` updates.
frame_err  output  1  one-cycle pulse on short frame or timeout.
busy  output  1  high while a frame is being received (SHIFT state).

Behaviour:
- Reset (`rst`=1 at posedge `clk`), synchronous, active-high:
  - outputs: `data_out`=0, `data_valid`=0, `frame_err`=0, `busy`=0;
  - internal: state=IDLE, bit_cnt=0, shift_reg=0, to_cnt=0;
  - registered copies: `sclk_q`=0, `cs_n_q`=1.
  - Reset mid-frame discards partial data with no error pulse.
- Edge detect: `sclk_q`/`cs_n_q` are registered every cycle.
  - sample_edge = `sclk` & !`sclk_q` when SAMPLE_RISING=1; !`sclk` & `sclk_q` when SAMPLE_RISING=0.
  - cs_fall = !`cs_n` & `cs_n_q`; cs_rise = `cs_n` & !`cs_n_q`.
  - `sdata` is sampled in the same cycle as sample_edge.
- States:
  - IDLE:
    - on cs_fall → SHIFT with bit_cnt=0, to_cnt=0, `busy`=1 from the next cycle.
    - sample edges while `cs_n`=1 are ignored.
    - if `cs_n` is already low out of reset (no falling edge), stay IDLE until a cs_fall occurs.
  - SHIFT:
    - on sample_edge: shift_reg <= {shift_reg[DATA_WIDTH-2:0], `sdata`}, bit_cnt+1, to_cnt=0.
    - if no sample_edge: to_cnt+1.
    - when the DATA_WIDTH-th bit is captured in cycle N:
      - `data_out` = completed word and `data_valid`=1 in cycle N+1 (one-cycle latency);
      - state → DONE.
    - sample_edge and cs_rise in the same cycle: the bit is captured first, then the cs_rise rule is evaluated with the updated count.
    - cs_rise with 0 < bit_cnt < DATA_WIDTH → `frame_err` pulse next cycle, → IDLE, `data_out` unchanged.
    - cs_rise with bit_cnt=0 → IDLE, no error.
    - to_cnt reaching TIMEOUT_CYCLES → `frame_err` pulse, → IDLE.
  - DONE:
    - extra sample edges are ignored; `busy`=0.
    - on cs_rise → IDLE; `cs_n` fall-then-rise is required before the next frame.
- `data_valid` and `frame_err` are never asserted in the same cycle; each is exactly 1 cycle wide.
- No synchronizers: `sclk`/`cs_n`/`sdata` are guaranteed same-domain.
- Minimum `sclk` half-period is 1 `clk` cycle.

Decomposition:
- Package `adc_pkg`:
  - state enum `adc_rx_state_t` {IDLE, SHIFT, DONE};
  - default ADC word width constant (12), shared with the clock divider testbench.
- Optional sub-module `edge_detect` (1-bit, registered input, rise/fall outputs), reused for `sclk` and `cs_n`.
- The shifter and FSM stay in the top module.

Test Plan:
1. Nominal frame:
   - stimulus: `sclk` from the divider with CLK_DIV_CT=5 (period 10 `clk`); `cs_n` low; 12 bits 0xA5C sent MSB-first on rising edges.
   - response: `data_out`=0xA5C, single-cycle `data_valid` one cycle after the 12th edge; `busy` high 1 cycle after cs_fall and low after completion.
2. Short frame:
   - stimulus: `cs_n` rises after 7 bits.
   - response: `frame_err` one cycle; `data_out` retains previous 0xA5C; no `data_valid`.
3. Timeout:
   - stimulus: TIMEOUT_CYCLES=16; `sclk` stops after 3 bits with `cs_n` held low.
   - response: `frame_err` pulse 16 cycles after the last edge; state IDLE; `busy`=0.
4. Overrun:
   - stimulus: 15 `sclk` edges in one frame carrying 0xFFF then 3 zeros.
   - response: `data_out`=0xFFF, exactly one `data_valid`; the next frame is accepted only after `cs_n` toggles.
5. Reset mid-frame:
   - stimulus: `rst` pulsed after 5 bits.
   - response: all outputs 0 the next cycle; no `frame_err`.
   - follow-up: a subsequent full frame of 0x123 yields `data_out`=0x123.
6. Falling-edge variant:
   - stimulus: SAMPLE_RISING=0, minimum `sclk` half-period of 1 cycle, word 0x801.
   - response: `data_out`=0x801 with correct one-cycle latency; back-to-back frames with 2 idle cycles both captured.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared ADC link definitions: receiver state encoding and the default conversion word width.
package adc_pkg;

    localparam int unsigned ADC_WORD_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } adc_rx_state_t;

endpackage

// File: rtl/edge_detect.sv
// Single-bit edge detector: registers the input and flags rising/falling transitions.
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Capture end of the ADC serial link: MSB-first shifter framed by cs_n, with
// short-frame and inter-edge timeout detection.
module adc_serial_rx
    import adc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = ADC_WORD_WIDTH,
    parameter bit          SAMPLE_RISING  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = $clog2(DATA_WIDTH + 1),
    parameter int unsigned TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, sample_edge;

    edge_detect #(.RESET_VAL(1'b0)) u_sclk_edge (
        .clk_i  (clk),
        .rst_i  (rst),
        .sig_i  (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    edge_detect #(.RESET_VAL(1'b1)) u_cs_edge (
        .clk_i  (clk),
        .rst_i  (rst),
        .sig_i  (cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    assign sample_edge = SAMPLE_RISING ? sclk_rise : sclk_fall;

    adc_rx_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d, cnt_upd;
    logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, word;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d, err_q, err_d, busy_q, busy_d;

    assign word = {shift_q[DATA_WIDTH-2:0], sdata};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = to_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        cnt_upd    = bit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                end
            end
            SHIFT: begin
                if (sample_edge) begin
                    shift_d  = word;
                    cnt_upd  = bit_cnt_q + CNT_WIDTH'(1);
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
                bit_cnt_d = cnt_upd;
                // The captured bit counts before cs_rise is judged.
                if (sample_edge && cnt_upd == CNT_WIDTH'(DATA_WIDTH)) begin
                    data_out_d = word;
                    valid_d    = 1'b1;
                    state_d    = cs_rise ? IDLE : DONE;
                end else if (cs_rise) begin
                    err_d   = (cnt_upd != '0);
                    state_d = IDLE;
                end else if (!sample_edge && to_cnt_d == TO_WIDTH'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule
